// File: rtl/vd_stream_frame_top.sv
// ---------------------------------------------------------------------------
// vd_stream_frame_top
//   Framed, back-pressured Viterbi decode top.
//   - Serialiser: splits each IN_W-bit coded word into SYM = IN_W/2 symbol
//     pairs (MSB pair first) and feeds one pair per cycle into the core.
//   - Tag pipe: carries "last symbol of frame" beside the core's fixed latency.
//   - Packer: collects decisions MSB-first into OUT_W-bit words and flushes a
//     zero-padded short word at frame end.
//   - Output FIFO: first-word fall-through, registered outputs, guarded by a
//     bit-credit counter so downstream stalls never lose a core decision.
// Ports
//   i_clk, i_rst_n           clock, async active-low reset
//   i_valid/i_ready          coded word handshake; i_data coded word,
//                            i_last marks the final word of a frame
//   o_valid/o_ready          decoded word handshake; o_data decisions
//                            (first in MSB), o_nbits valid bits,
//                            o_last final word of frame
// ---------------------------------------------------------------------------

// Behavioural stand-in for the Viterbi_decoding core: same interface and
// fixed latency. Hard decision on the systematic (first) bit of each pair.
//   i_valid/i_sym   one symbol pair per valid cycle
//   o_valid/o_dec   matching decision exactly DEC_LAT cycles later
module Viterbi_decoding #(
  parameter int DEC_LAT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [1:0] i_sym,
  output logic       o_valid,
  output logic       o_dec
);
  logic [DEC_LAT-1:0] vld_pipe;
  logic [DEC_LAT-1:0] dec_pipe;
  logic               unused_par;

  // Parity bit of the pair is not used by a hard systematic decision.
  assign unused_par = i_sym[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe <= '0;
      dec_pipe <= '0;
    end else begin
      vld_pipe[0] <= i_valid;
      dec_pipe[0] <= i_valid & i_sym[1];
      for (int k = 1; k < DEC_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        dec_pipe[k] <= dec_pipe[k-1];
      end
    end
  end

  assign o_valid = vld_pipe[DEC_LAT-1];
  assign o_dec   = dec_pipe[DEC_LAT-1];
endmodule

module vd_stream_frame_top #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int DEC_LAT    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [IN_W-1:0]            i_data,
  input  logic                       i_last,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [OUT_W-1:0]           o_data,
  output logic [$clog2(OUT_W+1)-1:0] o_nbits,
  output logic                       o_last
);
  localparam int SYM     = IN_W / 2;
  localparam int NBW     = $clog2(OUT_W + 1);
  localparam int CAP     = FIFO_DEPTH * OUT_W;
  localparam int CRW     = $clog2(CAP + SYM + OUT_W + 1);
  localparam int SCW     = (SYM > 1) ? $clog2(SYM) : 1;
  localparam int AW      = $clog2(OUT_W);
  localparam int AW1     = AW + 1;
  localparam int SYM_MOD = SYM % OUT_W;
  localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW    = $clog2(FIFO_DEPTH + 1);

  if (IN_W < 2 || (IN_W % 2) != 0) begin : g_bad_in_w
    $error("IN_W must be even and >= 2");
  end
  if (OUT_W < 2) begin : g_bad_out_w
    $error("OUT_W must be >= 2");
  end
  if (DEC_LAT < 1) begin : g_bad_lat
    $error("DEC_LAT must be >= 1");
  end
  if (FIFO_DEPTH * OUT_W < SYM) begin : g_bad_depth
    $error("FIFO_DEPTH*OUT_W must be >= IN_W/2");
  end

  typedef struct packed {
    logic             last;
    logic [NBW-1:0]   nbits;
    logic [OUT_W-1:0] data;
  } word_t;

  typedef enum logic {S_IDLE, S_SHIFT} ser_st_t;

  // ---------------- serialiser + credits ----------------
  ser_st_t          st;
  logic [IN_W-1:0]  shreg;
  logic [SCW-1:0]   sym_cnt;
  logic             last_q;
  logic             rdy_en;
  logic [AW-1:0]    align;     // frame bits accepted so far, mod OUT_W
  logic [CRW-1:0]   credits;
  logic [CRW-1:0]   credits_nxt;
  logic [AW1-1:0]   align_sum, align_wrap, pad_last;
  logic             final_sym, credit_ok, accept, pop;

  // Pad bits the frame would need if this word were its last. Reserving them
  // at accept time (rather than when the short word is pushed) means a frame
  // end can never push into a FIFO already promised to later words. The
  // check does not depend on i_last, so i_ready never looks at the payload.
  always_comb begin
    align_sum  = {1'b0, align} + AW1'(SYM_MOD);
    align_wrap = (align_sum >= AW1'(OUT_W)) ? align_sum - AW1'(OUT_W) : align_sum;
    pad_last   = (align_wrap == '0) ? '0 : AW1'(OUT_W) - align_wrap;
  end

  assign final_sym = (st == S_SHIFT) && (sym_cnt == SCW'(SYM - 1));
  assign credit_ok = credits >= (CRW'(SYM) + CRW'(pad_last));
  assign i_ready   = rdy_en & ((st == S_IDLE) | final_sym) & credit_ok;
  assign accept    = i_valid & i_ready;

  always_comb begin
    credits_nxt = credits;
    if (pop)    credits_nxt = credits_nxt + CRW'(OUT_W);
    if (accept) credits_nxt = credits_nxt - CRW'(SYM) - (i_last ? CRW'(pad_last) : '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st      <= S_IDLE;
      shreg   <= '0;
      sym_cnt <= '0;
      last_q  <= 1'b0;
      rdy_en  <= 1'b0;
      align   <= '0;
      credits <= CRW'(CAP);
    end else begin
      rdy_en  <= 1'b1;
      credits <= credits_nxt;
      if (accept) align <= i_last ? '0 : AW'(align_wrap);
      case (st)
        S_IDLE: begin
          if (accept) begin
            shreg   <= i_data;
            last_q  <= i_last;
            sym_cnt <= '0;
            st      <= S_SHIFT;
          end
        end
        default: begin
          if (final_sym) begin
            if (accept) begin  // back-to-back: reload without a bubble
              shreg   <= i_data;
              last_q  <= i_last;
              sym_cnt <= '0;
            end else begin
              st      <= S_IDLE;
            end
          end else begin
            shreg   <= shreg << 2;
            sym_cnt <= sym_cnt + SCW'(1);
          end
        end
      endcase
    end
  end

  // ---------------- core + tag pipe ----------------
  logic                core_vld, core_tag, dec_vld, dec_bit, tag_out;
  logic [1:0]          core_sym;
  logic [DEC_LAT-1:0]  tag_pipe;

  assign core_vld = (st == S_SHIFT);
  assign core_sym = shreg[IN_W-1 -: 2];
  assign core_tag = last_q & final_sym;

  Viterbi_decoding #(.DEC_LAT(DEC_LAT)) u_core (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (core_vld),
    .i_sym   (core_sym),
    .o_valid (dec_vld),
    .o_dec   (dec_bit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= core_tag;
      for (int k = 1; k < DEC_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end
  assign tag_out = tag_pipe[DEC_LAT-1];

  // ---------------- packer ----------------
  logic [OUT_W-1:0] acc, acc_n;
  logic [NBW-1:0]   cnt, cnt_n;
  logic             push;
  word_t            push_ent;

  always_comb begin
    acc_n          = {acc[OUT_W-2:0], dec_bit};
    cnt_n          = cnt + NBW'(1);
    push           = dec_vld & ((cnt_n == NBW'(OUT_W)) | tag_out);
    push_ent.last  = tag_out;
    push_ent.nbits = cnt_n;
    // Decisions sit right-aligned in acc; left-align so the first is the MSB.
    push_ent.data  = acc_n << (NBW'(OUT_W) - cnt_n);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (dec_vld) begin
      if (push) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_n;
        cnt <= cnt_n;
      end
    end
  end

  // ---------------- output FIFO ----------------
  word_t            mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_n;
  logic [CNTW-1:0]  f_cnt, f_cnt_n, ring_left;
  word_t            head_n;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop = o_valid & o_ready;

  // Next head is computed from the post-update state so the outputs can be
  // loaded straight into registers while keeping fall-through behaviour.
  always_comb begin
    rd_n      = pop ? ptr_inc(rd_ptr) : rd_ptr;
    f_cnt_n   = f_cnt + CNTW'(push) - CNTW'(pop);
    ring_left = f_cnt - CNTW'(pop);
    if (f_cnt_n == '0)        head_n = '0;
    else if (ring_left == '0) head_n = push_ent;
    else                      head_n = mem[rd_n];
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      f_cnt   <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_nbits <= '0;
      o_data  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr  <= rd_n;
      f_cnt   <= f_cnt_n;
      o_valid <= (f_cnt_n != '0);
      {o_last, o_nbits, o_data} <= head_n;
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(push && !pop && (f_cnt == CNTW'(FIFO_DEPTH))));
endmodule

// File: tb/tb_vd_stream_frame_top.sv
module tb_vd_stream_frame_top;
  localparam int IN_W = 16, OUT_W = 6, DEC_LAT = 4, FIFO_DEPTH = 6;
  localparam int SYM = IN_W / 2;
  localparam int NBW = $clog2(OUT_W + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_valid = 1'b0, i_last = 1'b0, i_ready;
  logic [IN_W-1:0]  i_data = '0;
  logic             o_valid, o_ready, o_last;
  logic [OUT_W-1:0] o_data;
  logic [NBW-1:0]   o_nbits;

  always #5 clk = ~clk;

  vd_stream_frame_top #(.IN_W(IN_W), .OUT_W(OUT_W), .DEC_LAT(DEC_LAT),
                        .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_nbits(o_nbits), .o_last(o_last));

  typedef struct {
    logic [OUT_W-1:0] data;
    int               nbits;
    bit               last;
  } exp_t;

  exp_t exp_q[$];
  bit   mbits[$];
  int   n_checks = 0, n_fail = 0, n_last = 0, cyc = 0, rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each symbol pair decodes to its first bit; the frame's
  // decisions are a bit stream cut into OUT_W chunks, the tail zero-padded.
  function automatic void emit(input int n, input bit last);
    exp_t e;
    e.data = '0;
    for (int i = 0; i < n; i++) e.data[OUT_W-1-i] = mbits.pop_front();
    e.nbits = n;
    e.last  = last;
    exp_q.push_back(e);
  endfunction

  function automatic void model_accept(input logic [IN_W-1:0] w, input bit last);
    for (int k = 0; k < SYM; k++) mbits.push_back(w[IN_W-1-2*k]);
    while (mbits.size() > OUT_W || (mbits.size() == OUT_W && !last)) emit(OUT_W, 1'b0);
    if (last) emit(mbits.size(), 1'b1);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_valid && o_ready) begin
      if (o_last) n_last++;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL word_unexpected: got %0h/%0d/%0b, expected no word", o_data, o_nbits, o_last);
      end else begin
        e = exp_q.pop_front();
        chk("word {last,nbits,data}", 64'({o_last, o_nbits, o_data}),
            64'({e.last, NBW'(e.nbits), e.data}));
      end
    end
  end

  // Downstream ready: 0 = always, 1 = stalled, 2 = random 50%
  initial begin
    o_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       o_ready = 1'b1;
        1:       o_ready = 1'b0;
        default: o_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_word(input logic [IN_W-1:0] d, input bit last, output int acc_cyc);
    int w = 0;
    bit got = 0;
    i_valid = 1'b1; i_data = d; i_last = last;
    while (!got && w < 1000) begin
      @(negedge clk);
      if (i_ready) got = 1; else w++;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: i_ready 0 for %0d cycles, expected 1", w);
      acc_cyc = -1;
    end else begin
      @(posedge clk);
      model_accept(d, last);
      #1 acc_cyc = cyc;
    end
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gaps);
    int c;
    for (int k = 0; k < n; k++) begin
      send_word(IN_W'($urandom), k == n - 1, c);
      if (gaps) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q.size() != 0 || o_valid) && w < 3000) begin
      @(posedge clk); w++;
    end
    #1 chk("drain_pending_words", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_i_ready"}, 64'(i_ready), 64'd0);
    chk({tag, "_o_valid"}, 64'(o_valid), 64'd0);
    chk({tag, "_o_data"},  64'(o_data),  64'd0);
    chk({tag, "_o_nbits"}, 64'(o_nbits), 64'd0);
    chk({tag, "_o_last"},  64'(o_last),  64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, prev, bubbles, nacc;
    bit take;
    logic [IN_W-1:0] d;

    // Reset state
    repeat (3) @(posedge clk);
    #1 chk_zero_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_reset", 64'(i_ready), 64'd1);

    // Single-word frame 0xE9A4
    rdy_mode = 0;
    send_word(16'hE9A4, 1'b1, c);
    wait_drain();

    // Three-word and five-word frames
    send_frame(3, 1'b0);
    wait_drain();
    send_frame(5, 1'b0);
    wait_drain();

    // Downstream stall with input held: 36 bits of room, 8 bits per word
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    nacc = 0;
    d = IN_W'($urandom);
    i_valid = 1'b1; i_data = d; i_last = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); take = i_ready;
      @(posedge clk);
      if (take) begin
        model_accept(d, 1'b0);
        nacc++;
        #1 d = IN_W'($urandom); i_data = d;
      end
    end
    #1;
    i_valid = 1'b0;
    chk("stall_accepts", 64'(nacc), 64'd4);
    chk("stall_i_ready", 64'(i_ready), 64'd0);
    rdy_mode = 0;
    send_word(IN_W'($urandom), 1'b0, c);
    send_word(IN_W'($urandom), 1'b1, c);
    wait_drain();

    // Back-to-back 10-word frames with random back-pressure
    rdy_mode = 2;
    n_last = 0;
    send_frame(10, 1'b0);
    send_frame(10, 1'b0);
    wait_drain();
    chk("last_count", 64'(n_last), 64'd2);

    // Throughput: accepts every SYM cycles across frame boundaries
    rdy_mode = 0;
    prev = -1; bubbles = 0;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 4; k++) begin
        send_word(IN_W'($urandom), k == 3, c);
        if (prev >= 0 && c - prev != SYM) bubbles++;
        prev = c;
      end
    wait_drain();
    chk("accept_bubbles", 64'(bubbles), 64'd0);

    // Reset in the middle of a frame
    rdy_mode = 2;
    for (int k = 0; k < 3; k++) send_word(IN_W'($urandom), 1'b0, c);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("midreset");
    exp_q.delete();
    mbits.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(4, 1'b1);
    wait_drain();

    // Random frames, gaps and back-pressure
    for (int f = 0; f < 12; f++) send_frame($urandom_range(1, 5), 1'b1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
